// File: rtl/fpu_add_sched.sv
// fpu_add_sched: round-robin scheduler sharing one single-precision adder among NREQ requesters.
// Contains the combinational IEEE-754 adder (round-to-nearest-even) it wraps.
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        w_swap, w_sub, w_nan, w_inf, w_hid;
    logic [31:0] w_l, w_s;
    logic [7:0]  w_el, w_es, w_d;
    logic [26:0] w_al, w_bs, w_as, w_norm;
    logic [27:0] w_raw;
    logic [4:0]  w_lz;
    logic [9:0]  w_e, w_sh, w_en, w_ef;
    logic [24:0] w_m;
    logic [22:0] w_frac;
    always_comb begin
        w_swap = b[30:0] > a[30:0];
        w_l = w_swap ? b : a;
        w_s = w_swap ? a : b;
        w_el = (w_l[30:23] == 8'd0) ? 8'd1 : w_l[30:23];
        w_es = (w_s[30:23] == 8'd0) ? 8'd1 : w_s[30:23];
        w_al = {|w_l[30:23], w_l[22:0], 3'b000};
        w_bs = {|w_s[30:23], w_s[22:0], 3'b000};
        w_d = w_el - w_es;
        // smaller operand aligned with guard, round and sticky bits
        w_as = (w_d > 8'd26) ? {26'd0, |w_bs}
             : ((w_bs >> w_d) | {26'd0, |(w_bs & ((27'd1 << w_d) - 27'd1))});
        w_sub = w_l[31] ^ w_s[31];
        w_raw = w_sub ? {1'b0, w_al} - {1'b0, w_as} : {1'b0, w_al} + {1'b0, w_as};
        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) if (w_raw[i]) w_lz = 5'(26 - i);
        w_e = {2'b00, w_el};
        w_sh = ({5'd0, w_lz} < w_e - 10'd1) ? {5'd0, w_lz} : w_e - 10'd1;
        w_norm = w_raw[27] ? {w_raw[27:2], |w_raw[1:0]} : w_raw[26:0] << w_sh;
        w_en = w_raw[27] ? w_e + 10'd1 : w_e - w_sh;
        w_m = {1'b0, w_norm[26:3]} + {24'd0, w_norm[2] & (|w_norm[1:0] | w_norm[3])};
        w_ef = w_m[24] ? w_en + 10'd1 : w_en;
        w_frac = w_m[24] ? w_m[23:1] : w_m[22:0];
        w_hid = w_m[24] | w_m[23];
        w_nan = (&a[30:23] & |a[22:0]) | (&b[30:23] & |b[22:0]) | (&a[30:23] & &b[30:23] & w_sub);
        w_inf = &a[30:23] | &b[30:23] | (w_ef >= 10'd255);
        sum = w_nan ? 32'h7FC00000
            : w_inf ? {w_l[31], 8'hFF, 23'd0}
            : (w_raw == 28'd0) ? {~w_sub & w_l[31], 31'd0}
            : {w_l[31], w_hid ? w_ef[7:0] : 8'd0, w_frac};
    end
endmodule

module fpu_add_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              busy,
    output logic [CNTW-1:0]   ops_done
);
    logic [IDW-1:0]  r_ptr, r_s1_id, r_rsp_id, w_g;
    logic            r_s1_valid, r_rsp_valid, w_found, w_s2_load, w_s1_free, w_accept;
    logic [31:0]     r_s1_a, r_s1_b, r_rsp_sum, w_sum;
    logic [CNTW-1:0] r_ops;

    adder u_adder (.a(r_s1_a), .b(r_s1_b), .sum(w_sum));

    assign w_s2_load = r_s1_valid && (!r_rsp_valid || rsp_ready);
    assign w_s1_free = !r_s1_valid || w_s2_load;
    assign w_accept  = w_found && w_s1_free;

    // lowest offset from ptr wins: descending scan, last hit overrides
    always_comb begin
        w_found = 1'b0;
        w_g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_g = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign req_ready = (w_accept && !rst) ? ({{(NREQ-1){1'b0}}, 1'b1} << w_g) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_ops       <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_id    <= w_g;
                r_s1_a     <= req_a[32*w_g +: 32];
                r_s1_b     <= req_b[32*w_g +: 32];
                r_ptr      <= (w_g == IDW'(NREQ - 1)) ? '0 : w_g + 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s2_load) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_s1_id;
                r_rsp_sum   <= w_sum;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            if (r_rsp_valid && rsp_ready) r_ops <= r_ops + 1'b1;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign busy      = r_s1_valid | r_rsp_valid;
    assign ops_done  = r_ops;
endmodule

// File: tb/tb_fpu_add_sched.sv
// tb_fpu_add_sched: directed self-checking bench for the round-robin adder scheduler.
module tb_fpu_add_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready, busy;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic [3:0]   ops_done;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [31:0]  fa [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0]  fs [4] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    fpu_add_sched #(.NREQ(4), .IDW(2), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
        step();
        step();
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready_hold got=%h exp=0", req_ready); end
        n_checks++; if ({rsp_valid, busy, rsp_id, ops_done} !== 8'h00) begin n_fail++; $display("FAIL reset_state got v=%b b=%b id=%0d ops=%0d exp all 0", rsp_valid, busy, rsp_id, ops_done); end
        n_checks++; if (rsp_sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", rsp_sum); end
        rst = 1'b0; req_valid = 4'h0;
        #1;
    endtask

    task automatic test_single();
        req_valid = 4'b0010; req_a[63:32] = 32'h3F800000; req_b[63:32] = 32'h40000000; rsp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'h0;
        n_checks++; if ({busy, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL single_s1 got busy=%b v=%b exp busy=1 v=0", busy, rsp_valid); end
        step();
        n_checks++; if ({rsp_valid, rsp_id} !== 3'b101) begin n_fail++; $display("FAIL single_rsp got v=%b id=%0d exp v=1 id=1", rsp_valid, rsp_id); end
        n_checks++; if (rsp_sum !== 32'h40400000) begin n_fail++; $display("FAIL single_sum got=%h exp=40400000", rsp_sum); end
        step();
        n_checks++; if ({rsp_valid, ops_done} !== 5'd1) begin n_fail++; $display("FAIL single_done got v=%b ops=%0d exp v=0 ops=1", rsp_valid, ops_done); end
    endtask

    task automatic test_equal_exp();
        req_valid = 4'b1000; req_a[127:96] = 32'h3F800000; req_b[127:96] = 32'h3FC00000;
        step();
        req_valid = 4'h0;
        step();
        n_checks++; if ({rsp_valid, rsp_id} !== 3'b111 || rsp_sum !== 32'h40200000) begin n_fail++; $display("FAIL equal_exp got v=%b id=%0d sum=%h exp v=1 id=3 sum=40200000", rsp_valid, rsp_id, rsp_sum); end
        step();
        n_checks++; if (ops_done !== 4'd2) begin n_fail++; $display("FAIL equal_exp_ops got=%0d exp=2", ops_done); end
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = fa[i];
            req_b[32*i +: 32] = 32'h3F800000;
        end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                n_checks++; if (req_ready !== (4'b0001 << (c % 4))) begin n_fail++; $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, 4'b0001 << (c % 4)); end
            end
            if (c >= 2) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4) || rsp_sum !== fs[(c - 2) % 4]) begin
                    n_fail++; $display("FAIL fair_rsp c=%0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h", c, rsp_valid, rsp_id, rsp_sum, (c - 2) % 4, fs[(c - 2) % 4]);
                end
            end
            step();
        end
        n_checks++; if ({rsp_valid, busy, ops_done} !== 6'd10) begin n_fail++; $display("FAIL fair_end got v=%b b=%b ops=%0d exp 0 0 10", rsp_valid, busy, ops_done); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000;
        req_a[95:64] = 32'h40000000; req_b[95:64] = 32'h40000000;
        req_valid = 4'b0101; rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rsp_ready = (c >= 5);
            if (c >= 5) req_valid = 4'h0;
            #1;
            if (c < 2) begin
                n_checks++; if (req_ready !== ((c == 0) ? 4'b0001 : 4'b0100)) begin n_fail++; $display("FAIL bp_accept c=%0d got=%b", c, req_ready); end
            end else if (c < 5) begin
                n_checks++; if (req_ready !== 4'h0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h40000000) begin
                    n_fail++; $display("FAIL bp_stall c=%0d got rdy=%b v=%b id=%0d sum=%h exp rdy=0 v=1 id=0 sum=40000000", c, req_ready, rsp_valid, rsp_id, rsp_sum);
                end
            end else if (c == 6) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h40800000) begin n_fail++; $display("FAIL bp_second got v=%b id=%0d sum=%h exp v=1 id=2 sum=40800000", rsp_valid, rsp_id, rsp_sum); end
            end
            if (rsp_valid && rsp_ready) hs++;
            step();
        end
        n_checks++; if (hs != 2 || ops_done !== 4'd12) begin n_fail++; $display("FAIL bp_count got hs=%0d ops=%0d exp hs=2 ops=12", hs, ops_done); end
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 1'b0; req_valid = 4'b0010;
        step();
        step();
        n_checks++; if ({busy, rsp_valid, req_ready} !== 6'b110000) begin n_fail++; $display("FAIL mid_full got b=%b v=%b rdy=%b exp 1 1 0000", busy, rsp_valid, req_ready); end
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
        step();
        rst = 1'b0; req_valid = 4'b1001;
        n_checks++; if ({rsp_valid, busy, ops_done} !== 6'd0) begin n_fail++; $display("FAIL mid_state got v=%b b=%b ops=%0d exp 0 0 0", rsp_valid, busy, ops_done); end
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
        rsp_ready = 1'b1;
        step();
        req_valid = 4'h0;
        step();
        step();
    endtask

    task automatic test_counter_wrap();
        int rsps = 0;
        do_reset();
        req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h3F800000; rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_valid = (c < 17) ? 4'b0001 : 4'h0;
            #1;
            if (rsp_valid) rsps++;
            step();
        end
        n_checks++; if (ops_done !== 4'd1 || rsps != 17) begin n_fail++; $display("FAIL wrap got ops=%0d rsps=%0d exp ops=1 rsps=17", ops_done, rsps); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_equal_exp();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_add_sched.md
# fpu_add_sched

Round-robin scheduler that shares one single-precision floating-point `adder` instance between `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle through a 2-stage registered pipeline wrapped around the combinational `adder`. Each result is returned with the ID of the requester that issued it. The block sits between the FPU VIP's request agents and the `adder`, and is the only driver of the adder's inputs.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 2: requester ID width; must equal ceil(log2(`NREQ`)), minimum 1.
- `CNTW`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  `NREQ`  bit i set: requester i presents an operand pair.
- `req_ready`  out  `NREQ`  bit i set: requester i's pair is accepted this cycle; one-hot or zero.
- `req_a`  in  `NREQ`*32  operand A, IEEE-754 single; requester i uses bits [32i+31:32i].
- `req_b`  in  `NREQ`*32  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result held in stage 2 is valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  `IDW`  requester index that issued the result.
- `rsp_sum`  out  32  sum returned by `adder` for that requester's operands.
- `busy`  out  1  stage 1 or stage 2 holds a valid operation.
- `ops_done`  out  `CNTW`  count of completed response handshakes; wraps modulo 2^`CNTW`.

## Operation
- Internal state:
  - `ptr` (`IDW` bits): round-robin priority pointer.
  - Stage 1 (S1): `s1_valid`, `s1_id`, `s1_a`, `s1_b`.
  - Stage 2 (S2): `rsp_valid`, `rsp_id`, `rsp_sum`.
  - `ops_done` counter.
- `adder` instantiation: one instance; `a`=`s1_a`, `b`=`s1_b`. Its `sum` output is captured into `rsp_sum`.
- Advance conditions:
  - `s2_load` = `s1_valid` && (!`rsp_valid` || `rsp_ready`).
  - `s1_free` = !`s1_valid` || `s2_load`.
- Arbitration (combinational): search indices `ptr`, `ptr`+1, …, `ptr`+`NREQ`-1 (mod `NREQ`). The first index with `req_valid` set is the grant `g`.
- Ready: `req_ready[g]` = `s1_free`; all other ready bits are 0. All bits are 0 when no request is valid.
- On accept (`req_valid[g]` && `req_ready[g]`):
  - S1 loads `{1, g, req_a[g], req_b[g]}`.
  - `ptr` becomes (`g`+1) mod `NREQ`.
- Without an accept: `ptr` holds. If `s2_load` is set, `s1_valid` clears.
- On `s2_load`: S2 loads `{1, s1_id, adder.sum}`.
- On `rsp_valid` && `rsp_ready` without `s2_load`: `rsp_valid` clears.
- Stall: while `rsp_valid` && !`rsp_ready`, S2 holds. S1 holds if valid; S1 may still fill if empty.
- `ops_done` increments by 1 on every `rsp_valid` && `rsp_ready` cycle and wraps from all-ones to 0.
- `busy` = `s1_valid` | `rsp_valid`.
- Numeric behaviour is exactly that of `adder`. The block does no rounding, special-value handling or operand modification.
- Requesters may deassert `req_valid` without being granted. No state is kept for ungranted requests.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `ops_done`=0, `ptr`=0, `s1_valid`=0, `busy`=0, `req_ready`=0 while `rst` is high.
- `req_ready` is combinational from `req_valid`, `ptr`, `s1_valid`, `rsp_valid` and `rsp_ready`. It is forced to 0 while `rst` is high.
- Latency: a pair accepted at edge N appears with `rsp_valid`=1 after edge N+1, i.e. 2 edges later. This holds when `rsp_ready` stays high.
- Throughput: 1 operation per cycle with `rsp_ready` held high.
- Simultaneous events:
  - In one cycle, S2 may hand off its result, S1 may move to S2 and a new request may enter S1.
  - No bubble is inserted.
- Full: when S1 and S2 are both valid and `rsp_ready`=0, every `req_ready` bit is 0.
- Outputs `rsp_id` and `rsp_sum` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Reset mid-operation: in-flight operations are discarded without any response, and all state returns to its reset values on the next edge.

## Test plan
- Single request:
  - Stimulus: requester 1 sends A=0x3F800000, B=0x40000000 with `rsp_ready`=1.
  - Required: `req_ready[1]` goes high in the same cycle; 2 edges later `rsp_valid`=1, `rsp_id`=1, `rsp_sum`=0x40400000 (3.0); `ops_done`=1.
- Fairness:
  - Stimulus: all 4 requesters hold `req_valid` high for 8 cycles.
  - Required: grants go in order 0,1,2,3,0,1,2,3, one per cycle; responses follow in the same order 2 cycles later.
- Equal exponents:
  - Stimulus: A=0x3F800000, B=0x3FC00000.
  - Required: `rsp_sum`=0x40200000 (2.5).
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles while requesters 0 and 2 stream operations.
  - Required: two operations are accepted, then `req_ready`=0 until `rsp_ready`=1; `rsp_id` and `rsp_sum` stay constant throughout; no operation is lost or duplicated.
- Reset mid-flight:
  - Stimulus: assert `rst` for 1 cycle with S1 and S2 both valid.
  - Required: next cycle `rsp_valid`=0, `busy`=0, `ops_done`=0; the next grant goes to requester 0.
- Counter wrap:
  - Stimulus: `CNTW`=4, complete 17 operations.
  - Required: `ops_done`=1.
